klein_reduce_sched: RTL and testbench
=====================================

KLEIN_REDUCE_SCHED -- requirements
Module: klein_reduce_sched

Interface
Parameters:
REQ-001 SHALL have parameter EXP_WIDTH_I, default 5, the FP exponent width.
REQ-002 SHALL have parameter MANT_WIDTH_I, default 2, the FP mantissa width; W = 1+EXP_WIDTH_I+MANT_WIDTH_I.
REQ-003 SHALL have parameter NUM_PARTIALS, default 4, the number of partial triples reduced per job; a power of 2, at least 2.
REQ-004 SHALL have parameter MERGE_LAT, default 4, the cycles from a merge issue to its result on merge_*_i; at least 1.
Ports:
REQ-005 SHALL have ports clk_i (in, 1, clock) and rst_i (in, 1, reset).
- One clock.
- Reset is synchronous and active-high.
REQ-006 SHALL have in_valid_i (in, 1) and in_ready_o (out, 1): the partial-input handshake.
REQ-007 SHALL have in_sum_i, in_cs_i, in_ccs_i (in, W each): the partial triple.
REQ-008 SHALL have out_valid_o (in/out: out, 1) and out_ready_i (in, 1): the result handshake.
REQ-009 SHALL have out_sum_o, out_cs_o, out_ccs_o (out, W each): the reduced triple.
REQ-010 SHALL have merge_issue_o (out, 1): the issue strobe to the shared merge pipeline.
REQ-011 SHALL have merge_sum_a_o, merge_sum_b_o, merge_cs_a_o, merge_cs_b_o, merge_ccs_a_o, merge_ccs_b_o (out, W each): the merge operands.
REQ-012 SHALL have merge_sum_i, merge_cs_i, merge_ccs_i (in, W each): the merge result, valid MERGE_LAT cycles after issue.
REQ-013 SHALL have busy_o (out, 1): high whenever the state is not LOAD, or the LOAD accept count is nonzero.

Function
REQ-014 SHALL implement the FSM states LOAD, REDUCE and OUT, with the buffer holding NUM_PARTIALS slots of {sum, cs, ccs}.
REQ-015 SHALL behave in LOAD as follows:
- in_ready_o=1.
- Each accept (in_valid_i & in_ready_o) writes slot[cnt] and increments cnt.
- The accept with cnt==NUM_PARTIALS-1 moves the FSM to REDUCE on the next cycle.
- in_ready_o=0 in REDUCE and OUT.
REQ-016 SHALL perform REDUCE as a level-by-level pairwise tree.
- Level size starts at P=NUM_PARTIALS/2 pairs.
- Pair k (k=0..P-1) is issued in cycle k of the level, the first level starting on the first REDUCE cycle.
- Operand a = slot[2k], operand b = slot[2k+1].
REQ-017 SHALL drive merge_issue_o=1 only on issue cycles, and drive all merge_*_o operand outputs to 0 when not issuing.
REQ-018 SHALL track issues with an internal MERGE_LAT-deep shift register of {valid, dest index k}.
- When its output is valid, merge_*_i is written to slot[k] in that cycle.
- merge_*_i is ignored at all other times.
REQ-019 SHALL start the next level (P halved) in the cycle after the level's last writeback; no issue overlaps a pending writeback of the same level.
REQ-020 SHALL enter OUT in the cycle after the writeback of the level with P=1; REDUCE then lasts sum over levels of (P+MERGE_LAT) cycles (11 cycles for the defaults).
REQ-021 SHALL behave in OUT as follows:
- out_valid_o=1 and out_*_o = slot[0].
- The outputs are held stable while out_ready_i=0.
- On out_ready_i=1 the FSM moves to LOAD with cnt=0 on the next cycle.
- out_valid_o=0 in other states, with out_*_o=0.
REQ-022 SHALL pass all arithmetic through unchanged; the controller performs no FP computation, and bit patterns are copied verbatim.
REQ-023 SHALL ignore in_valid_i outside LOAD, with no state change.

Reset
REQ-024 SHALL, when rst_i=1 at a clock edge, force the following:
- state=LOAD and cnt=0.
- Shift register cleared.
- Buffer slots=0.
- All outputs 0 except in_ready_o=1.
REQ-025 SHALL, on reset mid-REDUCE or mid-OUT, discard the job, and drop in-flight merge results arriving after reset (no slot write).

Verification
REQ-026 SHALL cover the basic job:
- Stimulus: defaults, bench merge model with 4-cycle delay; four triples sum=0x3C (1.0), cs=ccs=0 are accepted back-to-back.
- Response: issues with a=slot0/b=slot1 and a=slot2/b=slot3 in REDUCE cycles 0 and 1, then a single issue at cycle 6.
- Response: out_valid_o rises 11 cycles after REDUCE entry; with a reference Klein model, out_sum_o=0x44 and out_cs_o=out_ccs_o=0.
REQ-027 SHALL cover output backpressure: out_ready_i held 0 for 5 cycles -> out_* stable and out_valid_o=1 throughout; in_ready_o=0 until the cycle after out_ready_i=1.
REQ-028 SHALL cover gappy input: in_valid_i toggled 1,0,1,0,... -> exactly 4 accepts, slots in order, and REDUCE entered the cycle after the 4th accept.
REQ-029 SHALL cover reset mid-REDUCE: rst_i pulsed at REDUCE cycle 3 -> next cycle state=LOAD, in_ready_o=1, no slot writes from the in-flight results, and a following job produces a correct result.
REQ-030 SHALL cover a larger job: NUM_PARTIALS=8, MERGE_LAT=1 -> REDUCE lasts (4+1)+(2+1)+(1+1)=10 cycles, and the merge_*_o operands are 0 whenever merge_issue_o=0.

Source files
------------

// File: rtl/klein_reduce_sched.sv
// Klein-summation reduction scheduler.
// Collects NUM_PARTIALS {sum, cs, ccs} triples, reduces them pairwise, level by
// level, through a shared external merge pipeline of fixed latency MERGE_LAT,
// and presents the final triple. Bit patterns are only moved, never computed on.
//
// Handshakes: a transfer happens on a rising clk_i edge where valid and ready
// are both high. Producers hold valid and data stable until that edge.
// The result side holds out_valid_o and out_*_o stable until out_ready_i.
module klein_reduce_sched #(
  parameter int EXP_WIDTH_I  = 5,
  parameter int MANT_WIDTH_I = 2,
  parameter int NUM_PARTIALS = 4,
  parameter int MERGE_LAT    = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                in_valid_i,
  output logic                                in_ready_o,
  input  logic [EXP_WIDTH_I+MANT_WIDTH_I:0]   in_sum_i,
  input  logic [EXP_WIDTH_I+MANT_WIDTH_I:0]   in_cs_i,
  input  logic [EXP_WIDTH_I+MANT_WIDTH_I:0]   in_ccs_i,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic [EXP_WIDTH_I+MANT_WIDTH_I:0]   out_sum_o,
  output logic [EXP_WIDTH_I+MANT_WIDTH_I:0]   out_cs_o,
  output logic [EXP_WIDTH_I+MANT_WIDTH_I:0]   out_ccs_o,
  output logic                                merge_issue_o,
  output logic [EXP_WIDTH_I+MANT_WIDTH_I:0]   merge_sum_a_o,
  output logic [EXP_WIDTH_I+MANT_WIDTH_I:0]   merge_sum_b_o,
  output logic [EXP_WIDTH_I+MANT_WIDTH_I:0]   merge_cs_a_o,
  output logic [EXP_WIDTH_I+MANT_WIDTH_I:0]   merge_cs_b_o,
  output logic [EXP_WIDTH_I+MANT_WIDTH_I:0]   merge_ccs_a_o,
  output logic [EXP_WIDTH_I+MANT_WIDTH_I:0]   merge_ccs_b_o,
  input  logic [EXP_WIDTH_I+MANT_WIDTH_I:0]   merge_sum_i,
  input  logic [EXP_WIDTH_I+MANT_WIDTH_I:0]   merge_cs_i,
  input  logic [EXP_WIDTH_I+MANT_WIDTH_I:0]   merge_ccs_i,
  output logic                                busy_o,
  output logic [1:0]                          state_o
);

  localparam int W  = 1 + EXP_WIDTH_I + MANT_WIDTH_I;
  localparam int CW = $clog2(NUM_PARTIALS);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_REDUCE = 2'd1,
    ST_OUT    = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;      // LOAD slot write pointer
  logic [CW-1:0]   p_q;        // pairs in the current level
  logic [CW-1:0]   k_q;        // next pair to issue in the current level
  logic [W-1:0]    sum_q [NUM_PARTIALS];
  logic [W-1:0]    cs_q  [NUM_PARTIALS];
  logic [W-1:0]    ccs_q [NUM_PARTIALS];
  logic            sr_vld_q [MERGE_LAT];
  logic [CW-1:0]   sr_idx_q [MERGE_LAT];

  logic            accept;
  logic            issue;
  logic            wb_vld;
  logic [CW-1:0]   wb_idx;
  logic            level_done;
  logic [CW-1:0]   idx_a, idx_b;

  assign accept     = (state_q == ST_LOAD) && in_valid_i;
  assign issue      = (state_q == ST_REDUCE) && (k_q < p_q);
  assign wb_vld     = sr_vld_q[MERGE_LAT-1] && (state_q == ST_REDUCE);
  assign wb_idx     = sr_idx_q[MERGE_LAT-1];
  // Writebacks return in issue order, so the last pair's writeback ends the level.
  assign level_done = wb_vld && (wb_idx == p_q - CW'(1));
  assign idx_a      = CW'({k_q, 1'b0});
  assign idx_b      = idx_a + CW'(1);
  assign state_o    = state_q;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_LOAD;
    else       state_q <= state_d;
  end

  // Next-state logic and all handshake/merge/result outputs.
  always_comb begin
    state_d       = state_q;
    in_ready_o    = 1'b0;
    out_valid_o   = 1'b0;
    out_sum_o     = '0;
    out_cs_o      = '0;
    out_ccs_o     = '0;
    merge_issue_o = issue;
    merge_sum_a_o = '0;
    merge_sum_b_o = '0;
    merge_cs_a_o  = '0;
    merge_cs_b_o  = '0;
    merge_ccs_a_o = '0;
    merge_ccs_b_o = '0;
    busy_o        = (state_q != ST_LOAD) || (cnt_q != '0);
    if (issue) begin
      merge_sum_a_o = sum_q[idx_a];
      merge_sum_b_o = sum_q[idx_b];
      merge_cs_a_o  = cs_q[idx_a];
      merge_cs_b_o  = cs_q[idx_b];
      merge_ccs_a_o = ccs_q[idx_a];
      merge_ccs_b_o = ccs_q[idx_b];
    end
    case (state_q)
      ST_LOAD: begin
        in_ready_o = 1'b1;
        if (accept && (cnt_q == CW'(NUM_PARTIALS - 1))) state_d = ST_REDUCE;
      end
      ST_REDUCE: begin
        if (level_done && (p_q == CW'(1))) state_d = ST_OUT;
      end
      ST_OUT: begin
        out_valid_o = 1'b1;
        out_sum_o   = sum_q[0];
        out_cs_o    = cs_q[0];
        out_ccs_o   = ccs_q[0];
        if (out_ready_i) state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Slot buffer, load pointer, level/pair counters and the in-flight tracker.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      p_q   <= CW'(NUM_PARTIALS / 2);
      k_q   <= '0;
      for (int i = 0; i < NUM_PARTIALS; i++) begin
        sum_q[i] <= '0;
        cs_q[i]  <= '0;
        ccs_q[i] <= '0;
      end
      for (int i = 0; i < MERGE_LAT; i++) begin
        sr_vld_q[i] <= 1'b0;
        sr_idx_q[i] <= '0;
      end
    end else begin
      // Pointer wraps to 0 on the last accept since NUM_PARTIALS is a power of 2.
      if (accept) begin
        sum_q[cnt_q] <= in_sum_i;
        cs_q[cnt_q]  <= in_cs_i;
        ccs_q[cnt_q] <= in_ccs_i;
        cnt_q        <= cnt_q + CW'(1);
        p_q          <= CW'(NUM_PARTIALS / 2);
        k_q          <= '0;
      end
      sr_vld_q[0] <= issue;
      sr_idx_q[0] <= k_q;
      for (int i = 1; i < MERGE_LAT; i++) begin
        sr_vld_q[i] <= sr_vld_q[i-1];
        sr_idx_q[i] <= sr_idx_q[i-1];
      end
      if (issue) k_q <= k_q + CW'(1);
      if (wb_vld) begin
        sum_q[wb_idx] <= merge_sum_i;
        cs_q[wb_idx]  <= merge_cs_i;
        ccs_q[wb_idx] <= merge_ccs_i;
      end
      if (level_done && (p_q != CW'(1))) begin
        p_q <= p_q >> 1;
        k_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_klein_reduce_sched.sv
// Directed bench for klein_reduce_sched: a default instance (4 partials,
// merge latency 4) and a larger one (8 partials, merge latency 1), each fed by
// a behavioural e5m2 Klein merge model with the matching latency.
module tb_klein_reduce_sched;

  localparam int W    = 8;
  localparam int BIAS = 15;

  typedef struct packed {
    logic [8*W-1:0] s;
    logic [8*W-1:0] c;
    logic [8*W-1:0] k;
    logic [W-1:0]   es;
    logic [W-1:0]   ec;
    logic [W-1:0]   ek;
  } vec_t;

  logic         clk_i;
  logic         rst_i;
  logic         in_valid  [2];
  logic         in_ready  [2];
  logic [W-1:0] in_sum    [2];
  logic [W-1:0] in_cs     [2];
  logic [W-1:0] in_ccs    [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [W-1:0] out_sum   [2];
  logic [W-1:0] out_cs    [2];
  logic [W-1:0] out_ccs   [2];
  logic         issue     [2];
  logic [W-1:0] m_sa [2], m_sb [2], m_ca [2], m_cb [2], m_ka [2], m_kb [2];
  logic [W-1:0] m_s  [2], m_c  [2], m_k  [2];
  logic         busy      [2];
  logic [1:0]   st        [2];
  logic [3*W-1:0] pipe [2][4];

  int n_checks;
  int n_fail;

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- DUTs ----------------
  klein_reduce_sched #(.EXP_WIDTH_I(5), .MANT_WIDTH_I(2), .NUM_PARTIALS(4), .MERGE_LAT(4)) dut0 (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .in_sum_i(in_sum[0]), .in_cs_i(in_cs[0]), .in_ccs_i(in_ccs[0]),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
    .out_sum_o(out_sum[0]), .out_cs_o(out_cs[0]), .out_ccs_o(out_ccs[0]),
    .merge_issue_o(issue[0]),
    .merge_sum_a_o(m_sa[0]), .merge_sum_b_o(m_sb[0]),
    .merge_cs_a_o(m_ca[0]), .merge_cs_b_o(m_cb[0]),
    .merge_ccs_a_o(m_ka[0]), .merge_ccs_b_o(m_kb[0]),
    .merge_sum_i(m_s[0]), .merge_cs_i(m_c[0]), .merge_ccs_i(m_k[0]),
    .busy_o(busy[0]), .state_o(st[0])
  );

  klein_reduce_sched #(.EXP_WIDTH_I(5), .MANT_WIDTH_I(2), .NUM_PARTIALS(8), .MERGE_LAT(1)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .in_sum_i(in_sum[1]), .in_cs_i(in_cs[1]), .in_ccs_i(in_ccs[1]),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
    .out_sum_o(out_sum[1]), .out_cs_o(out_cs[1]), .out_ccs_o(out_ccs[1]),
    .merge_issue_o(issue[1]),
    .merge_sum_a_o(m_sa[1]), .merge_sum_b_o(m_sb[1]),
    .merge_cs_a_o(m_ca[1]), .merge_cs_b_o(m_cb[1]),
    .merge_ccs_a_o(m_ka[1]), .merge_ccs_b_o(m_kb[1]),
    .merge_sum_i(m_s[1]), .merge_cs_i(m_c[1]), .merge_ccs_i(m_k[1]),
    .busy_o(busy[1]), .state_o(st[1])
  );

  // ---------------- e5m2 Klein merge model ----------------
  function automatic real dec(input logic [W-1:0] x);
    logic [4:0] e;
    logic [1:0] m;
    real r;
    e = x[6:2];
    m = x[1:0];
    if (e == 5'd0) return 0.0;
    r = 1.0 + real'(m) / 4.0;
    for (int i = 0; i < int'(e) - BIAS; i++) r = r * 2.0;
    for (int i = 0; i < BIAS - int'(e); i++) r = r / 2.0;
    return x[7] ? -r : r;
  endfunction

  function automatic logic [W-1:0] enc(input real v);
    logic sgn;
    real a;
    int e, mi, be;
    logic [4:0] eb;
    logic [1:0] mb;
    if (v == 0.0) return '0;
    sgn = (v < 0.0);
    a = sgn ? -v : v;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    mi = $rtoi((a - 1.0) * 4.0 + 0.5);
    if (mi == 4) begin mi = 0; e++; end
    be = e + BIAS;
    if (be <= 0) return {sgn, 7'd0};
    if (be >= 31) begin be = 30; mi = 3; end
    eb = be[4:0];
    mb = mi[1:0];
    return {sgn, eb, mb};
  endfunction

  function automatic logic [3*W-1:0] merge(input logic [W-1:0] sa, sb, ca, cb, ka, kb);
    real sx, res;
    logic [W-1:0] s, c, k;
    sx  = dec(sa) + dec(sb);
    s   = enc(sx);
    res = sx - dec(s);
    c   = enc(dec(ca) + dec(cb) + res);
    k   = enc(dec(ka) + dec(kb));
    return {s, c, k};
  endfunction

  // Merge pipelines; idle slots carry a junk pattern that must never be written back.
  always @(posedge clk_i) begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 3; i > 0; i--) pipe[d][i] <= pipe[d][i-1];
      pipe[d][0] <= issue[d] ? merge(m_sa[d], m_sb[d], m_ca[d], m_cb[d], m_ka[d], m_kb[d])
                             : {3{8'hA5}};
    end
  end

  assign m_s[0] = pipe[0][3][3*W-1:2*W];
  assign m_c[0] = pipe[0][3][2*W-1:W];
  assign m_k[0] = pipe[0][3][W-1:0];
  assign m_s[1] = pipe[1][0][3*W-1:2*W];
  assign m_c[1] = pipe[1][0][2*W-1:W];
  assign m_k[1] = pipe[1][0][W-1:0];

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] el(input logic [8*W-1:0] x, input int i);
    return x[i*W +: W];
  endfunction

  function automatic logic [8*W-1:0] mk4(input logic [W-1:0] a0, a1, a2, a3);
    return {32'h0, a3, a2, a1, a0};
  endfunction

  // ---------------- drivers ----------------
  task automatic load_job(input int d, input vec_t v, input bit gappy, output int acc);
    int n;
    n = (d != 0) ? 8 : 4;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      in_sum[d]   = el(v.s, i);
      in_cs[d]    = el(v.c, i);
      in_ccs[d]   = el(v.k, i);
      in_valid[d] = 1'b1;
      if (in_ready[d]) acc++;
      @(posedge clk_i); #1;
      if (gappy && i < n - 1) begin
        in_valid[d] = 1'b0;
        in_sum[d]   = 8'hFF;
        in_cs[d]    = 8'hFF;
        in_ccs[d]   = 8'hFF;
        @(posedge clk_i); #1;
      end
    end
    in_valid[d] = 1'b0;
    in_sum[d]   = '0;
    in_cs[d]    = '0;
    in_ccs[d]   = '0;
  endtask

  task automatic run_job(input int d, input vec_t v, input bit gappy, input int stall);
    int n, acc, cyc, lat, bad_zero, bad_rdy, bad_hold;
    logic [7:0] exp_q[$];
    logic [6*W-1:0] ops, eops;
    logic [3*W-1:0] hold;
    n   = (d != 0) ? 8 : 4;
    lat = (d != 0) ? 10 : 11;
    if (d != 0) begin
      exp_q.push_back(8'd0); exp_q.push_back(8'd1); exp_q.push_back(8'd2); exp_q.push_back(8'd3);
      exp_q.push_back(8'd5); exp_q.push_back(8'd6); exp_q.push_back(8'd8);
    end else begin
      exp_q.push_back(8'd0); exp_q.push_back(8'd1); exp_q.push_back(8'd6);
    end
    load_job(d, v, gappy, acc);
    chk("accept_count", acc, n);
    chk("reduce_entry_state", st[d], 2'd1);
    cyc = 0; bad_zero = 0; bad_rdy = 0;
    while (!out_valid[d] && cyc < 40) begin
      if (in_ready[d]) bad_rdy++;
      if (issue[d]) begin
        if (exp_q.size() == 0) chk("unexpected_issue_cycle", cyc, 255);
        else chk("issue_cycle", cyc, exp_q.pop_front());
        if (cyc < n / 2) begin
          ops  = {m_sa[d], m_sb[d], m_ca[d], m_cb[d], m_ka[d], m_kb[d]};
          eops = {el(v.s, 2*cyc), el(v.s, 2*cyc+1), el(v.c, 2*cyc), el(v.c, 2*cyc+1),
                  el(v.k, 2*cyc), el(v.k, 2*cyc+1)};
          chk("level0_operands", ops, eops);
        end
      end else if ({m_sa[d], m_sb[d], m_ca[d], m_cb[d], m_ka[d], m_kb[d]} != '0) begin
        bad_zero++;
      end
      @(posedge clk_i); #1;
      cyc++;
    end
    chk("reduce_cycles", cyc, lat);
    chk("issues_outstanding", exp_q.size(), 0);
    chk("idle_operands_zero", bad_zero, 0);
    chk("in_ready_low_in_reduce", bad_rdy, 0);
    chk("out_sum", out_sum[d], v.es);
    chk("out_cs", out_cs[d], v.ec);
    chk("out_ccs", out_ccs[d], v.ek);
    hold = {out_sum[d], out_cs[d], out_ccs[d]};
    bad_hold = 0;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk_i); #1;
      if (!out_valid[d] || in_ready[d] || ({out_sum[d], out_cs[d], out_ccs[d]} != hold)) bad_hold++;
    end
    chk("out_hold_stable", bad_hold, 0);
    out_ready[d] = 1'b1;
    chk("in_ready_low_in_out", in_ready[d], 1'b0);
    @(posedge clk_i); #1;
    out_ready[d] = 1'b0;
    chk("back_to_load_state", st[d], 2'd0);
    chk("in_ready_after_out", in_ready[d], 1'b1);
    chk("out_valid_after_out", out_valid[d], 1'b0);
    chk("busy_after_out", busy[d], 1'b0);
    chk("out_sum_zero_in_load", out_sum[d], 8'h00);
  endtask

  // ---------------- main sequence ----------------
  vec_t tbl [4];
  vec_t big;

  initial begin
    int acc;
    n_checks = 0;
    n_fail   = 0;
    rst_i    = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_sum[d] = '0; in_cs[d] = '0; in_ccs[d] = '0;
      out_ready[d] = 1'b0;
    end
    // Vectors: e5m2, 0x3C=1.0, 0x40=2.0, 0x44=4.0, 0x38=0.5, 0xBC=-1.0, 0x3E=1.5
    tbl[0] = '{s: mk4(8'h3C, 8'h3C, 8'h3C, 8'h3C), c: '0, k: '0,
               es: 8'h44, ec: 8'h00, ek: 8'h00};
    tbl[1] = '{s: mk4(8'h40, 8'h40, 8'h44, 8'h44), c: mk4(8'h3C, 8'h00, 8'h00, 8'h00), k: '0,
               es: 8'h4A, ec: 8'h3C, ek: 8'h00};
    tbl[2] = '{s: mk4(8'h3C, 8'hBC, 8'h40, 8'hC0), c: mk4(8'h38, 8'h38, 8'h38, 8'h38),
               k: mk4(8'h3C, 8'h00, 8'h00, 8'h3C), es: 8'h00, ec: 8'h40, ek: 8'h40};
    tbl[3] = '{s: mk4(8'h3E, 8'h3E, 8'h40, 8'h3C), c: '0, k: '0,
               es: 8'h46, ec: 8'h00, ek: 8'h00};
    big    = '{s: {8{8'h3C}}, c: {8{8'h38}}, k: '0, es: 8'h48, ec: 8'h44, ek: 8'h00};

    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("reset_state", st[d], 2'd0);
      chk("reset_in_ready", in_ready[d], 1'b1);
      chk("reset_out_valid", out_valid[d], 1'b0);
      chk("reset_issue", issue[d], 1'b0);
      chk("reset_busy", busy[d], 1'b0);
      chk("reset_out_sum", out_sum[d], 8'h00);
    end

    // Table: vector 1 with 5-cycle backpressure, vector 2 with gappy input.
    for (int t = 0; t < 4; t++) run_job(0, tbl[t], (t == 2), (t == 1) ? 5 : 0);

    // Reset at REDUCE cycle 3 with results still in flight, then a fresh job.
    load_job(0, tbl[1], 1'b0, acc);
    chk("rst_job_accepts", acc, 4);
    repeat (3) begin @(posedge clk_i); #1; end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk("mid_reduce_rst_state", st[0], 2'd0);
    chk("mid_reduce_rst_in_ready", in_ready[0], 1'b1);
    chk("mid_reduce_rst_busy", busy[0], 1'b0);
    chk("mid_reduce_rst_issue", issue[0], 1'b0);
    run_job(0, tbl[2], 1'b0, 0);

    // Larger configuration.
    run_job(1, big, 1'b0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t limit=200000", $time);
    $fatal(1);
  end

endmodule
